// File: rtl/ula_pkg.sv
// Shared ALU opcodes, error-cause bit positions and monitor FSM encoding.
// Constants only; no latency, no flow control.
package ula_pkg;

    localparam logic [2:0] OP_DIV      = 3'b110;
    localparam logic [2:0] OP_INV      = 3'b111;
    localparam int         ERR_DIV_BIT = 0;
    localparam int         ERR_OP_BIT  = 1;

    // Wide enough for the largest legal BLINK_DIV (2^26-1).
    localparam int         PHASE_W     = 26;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_ALERT    = 2'd1,
        ST_WAIT_REL = 2'd2
    } mon_state_t;

    function automatic logic [1:0] err_bits(input logic div_err, input logic op_err);
        logic [1:0] v;
        v              = 2'b00;
        v[ERR_DIV_BIT] = div_err;
        v[ERR_OP_BIT]  = op_err;
        return v;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector: pulse for the cycle the input goes 0->1.
// Zero-cycle output from the live input; a held-high level yields one pulse.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/error_monitor.sv
// ALU error monitor: sticky cause bits, blinking LED, ack-driven clear; 1-cycle latency.
// No backpressure. ERROR_MONITOR_COUNT_EN adds the saturating error-event counter.
module error_monitor
    import ula_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    input  logic [2:0] seletor,
    input  logic [3:0] b,
    input  logic       ack,
    output logic       ledr9,
    output logic [1:0] err_code,
    output logic [3:0] err_count
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BLINK_DIV - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = {{(PHASE_W-1){1'b0}}, 1'b1};

    mon_state_t         r_state;
    mon_state_t         w_state_nxt;
    logic               r_led;
    logic               w_led_nxt;
    logic [1:0]         r_code;
    logic [1:0]         w_code_nxt;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_nxt;

    logic       w_div_err;
    logic       w_op_err;
    logic       w_err;
    logic [1:0] w_new_bits;
    logic       w_ack_rise;

    assign w_div_err  = op_valid && (seletor == OP_DIV) && (b == 4'b0000);
    assign w_op_err   = op_valid && (seletor == OP_INV);
    assign w_err      = w_div_err | w_op_err;
    assign w_new_bits = err_bits(w_div_err, w_op_err);

    edge_rise u_ack_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (ack),
        .o_rise (w_ack_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OK;
            r_led   <= 1'b0;
            r_code  <= 2'b00;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_led   <= w_led_nxt;
            r_code  <= w_code_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_led_nxt   = r_led;
        w_code_nxt  = r_code;
        w_phase_nxt = r_phase;

        case (r_state)
            ST_OK: begin
                if (w_err) begin
                    w_state_nxt = ST_ALERT;
                    w_code_nxt  = w_new_bits;
                    w_led_nxt   = 1'b1;
                    w_phase_nxt = '0;
                end
            end

            ST_ALERT: begin
                if (w_err && w_ack_rise) begin
                    // Ack collides with a fresh error: only the new cause survives.
                    w_code_nxt  = w_new_bits;
                    w_led_nxt   = 1'b1;
                    w_phase_nxt = '0;
                end else if (w_ack_rise) begin
                    w_state_nxt = ST_WAIT_REL;
                    w_code_nxt  = 2'b00;
                    w_led_nxt   = 1'b0;
                    w_phase_nxt = '0;
                end else begin
                    if (w_err) begin
                        w_code_nxt = r_code | w_new_bits;
                    end
                    if (r_phase == PHASE_LAST) begin
                        w_led_nxt   = ~r_led;
                        w_phase_nxt = '0;
                    end else begin
                        w_phase_nxt = r_phase + PHASE_ONE;
                    end
                end
            end

            ST_WAIT_REL: begin
                if (w_err) begin
                    w_state_nxt = ST_ALERT;
                    w_code_nxt  = w_new_bits;
                    w_led_nxt   = 1'b1;
                    w_phase_nxt = '0;
                end else if (!ack) begin
                    w_state_nxt = ST_OK;
                end
            end

            default: begin
                w_state_nxt = ST_OK;
                w_led_nxt   = 1'b0;
                w_code_nxt  = 2'b00;
                w_phase_nxt = '0;
            end
        endcase
    end

    assign ledr9    = r_led;
    assign err_code = r_code;

`ifdef ERROR_MONITOR_COUNT_EN
    logic [3:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 4'd0;
        end else if (w_err && (r_err_cnt != 4'hF)) begin
            r_err_cnt <= r_err_cnt + 4'd1;
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 4'b0000;
`endif

endmodule

// File: tb/tb_error_monitor.sv
// Randomized + directed bench for error_monitor against a cycle-level reference model.
module tb_error_monitor;

    localparam int DIV  = 4;
    localparam int M_OK = 0, M_ALERT = 1, M_WAIT = 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       op_valid = 1'b0;
    logic [2:0] seletor  = 3'b000;
    logic [3:0] b        = 4'b0000;
    logic       ack      = 1'b0;
    logic       ledr9;
    logic [1:0] err_code;
    logic [3:0] err_count;

    error_monitor #(.BLINK_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .seletor   (seletor),
        .b         (b),
        .ack       (ack),
        .ledr9     (ledr9),
        .err_code  (err_code),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode, cycles spent in ALERT since last (re)start, causes, events.
    int         m_mode;
    int         m_age;
    logic [1:0] m_code;
    int         m_cnt;
    logic       m_prev_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_led();
        return (m_mode == M_ALERT) && (((m_age / DIV) % 2) == 0);
    endfunction

    function automatic int exp_cnt();
`ifdef ERROR_MONITOR_COUNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_mode     = M_OK;
        m_age      = 0;
        m_code     = 2'b00;
        m_cnt      = 0;
        m_prev_ack = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic       de, oe, err, rise;
        logic [1:0] nb;
        de   = op_valid && (seletor == 3'b110) && (b == 4'd0);
        oe   = op_valid && (seletor == 3'b111);
        err  = de | oe;
        nb   = {oe, de};
        rise = ack && !m_prev_ack;
        m_prev_ack = ack;
        if (err && m_cnt < 15) m_cnt++;
        case (m_mode)
            M_OK: if (err) begin m_mode = M_ALERT; m_age = 0; m_code = nb; end
            M_ALERT: begin
                if (err && rise) begin m_code = nb; m_age = 0; end
                else if (rise) begin m_mode = M_WAIT; m_code = 2'b00; end
                else begin
                    if (err) m_code = m_code | nb;
                    m_age++;
                end
            end
            default: begin
                if (err) begin m_mode = M_ALERT; m_age = 0; m_code = nb; end
                else if (!ack) m_mode = M_OK;
            end
        endcase
    endtask

    task automatic check_outs();
        chk("ledr9", 32'(ledr9), 32'(exp_led()));
        chk("err_code", 32'(err_code), 32'(m_code));
        chk("err_count", 32'(err_count), 32'(exp_cnt()));
    endtask

    // Called at a negedge: drive, step model, wait to next negedge, compare.
    task automatic cyc(input logic v, input logic [2:0] s, input logic [3:0] bb, input logic a);
        op_valid = v;
        seletor  = s;
        b        = bb;
        ack      = a;
        model_step();
        @(negedge clk);
        check_outs();
    endtask

    // Reset asserted between edges; outputs must clear before the next clock.
    task automatic do_reset(input string tag);
        #2;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        ack      = 1'b0;
        #1;
        chk({tag, "_led_async"}, 32'(ledr9), 0);
        chk({tag, "_code_async"}, 32'(err_code), 0);
        chk({tag, "_cnt_async"}, 32'(err_count), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outs();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset("por");

        // Divide-by-zero, then blink with half-period DIV.
        cyc(1'b1, 3'b110, 4'd0, 1'b0);
        chk("div_code", 32'(err_code), 1);
        chk("div_led", 32'(ledr9), 1);
        for (int i = 0; i < DIV - 1; i++) cyc(1'b0, 3'b000, 4'd0, 1'b0);
        chk("blink_still_high", 32'(ledr9), 1);
        cyc(1'b0, 3'b000, 4'd0, 1'b0);
        chk("blink_low", 32'(ledr9), 0);
        for (int i = 0; i < DIV; i++) cyc(1'b0, 3'b000, 4'd0, 1'b0);
        chk("blink_high_again", 32'(ledr9), 1);
        cyc(1'b0, 3'b000, 4'd0, 1'b1);
        cyc(1'b0, 3'b000, 4'd0, 1'b0);

        // Non-error operations.
        cyc(1'b1, 3'b110, 4'd5, 1'b0);
        cyc(1'b1, 3'b101, 4'd0, 1'b0);
        chk("noerr_code", 32'(err_code), 0);
        chk("noerr_led", 32'(ledr9), 0);

        // Accumulate both causes, then acknowledge.
        do_reset("r1");
        cyc(1'b1, 3'b110, 4'd0, 1'b0);
        cyc(1'b1, 3'b111, 4'd3, 1'b0);
        chk("both_code", 32'(err_code), 3);
`ifdef ERROR_MONITOR_COUNT_EN
        chk("both_cnt", 32'(err_count), 2);
`else
        chk("both_cnt", 32'(err_count), 0);
`endif
        cyc(1'b0, 3'b000, 4'd0, 1'b1);
        chk("ack_code", 32'(err_code), 0);
        chk("ack_led", 32'(ledr9), 0);
        cyc(1'b0, 3'b000, 4'd0, 1'b0);
        cyc(1'b0, 3'b000, 4'd0, 1'b1);   // ignored in OK
        cyc(1'b0, 3'b000, 4'd0, 1'b0);
        chk("ok_led", 32'(ledr9), 0);

        // Ack edge and new error in the same cycle.
        cyc(1'b1, 3'b110, 4'd0, 1'b0);
        cyc(1'b1, 3'b111, 4'd0, 1'b1);
        chk("collide_code", 32'(err_code), 2);
        chk("collide_led", 32'(ledr9), 1);
        cyc(1'b0, 3'b000, 4'd0, 1'b1);   // held level: no second edge
        chk("held_ack_code", 32'(err_code), 2);
        cyc(1'b0, 3'b000, 4'd0, 1'b0);
        cyc(1'b0, 3'b000, 4'd0, 1'b1);
        chk("clear_code", 32'(err_code), 0);
        cyc(1'b0, 3'b000, 4'd0, 1'b0);

        // Saturation after 17 events.
        for (int i = 0; i < 17; i++) cyc(1'b1, 3'b111, 4'($urandom), 1'b0);
`ifdef ERROR_MONITOR_COUNT_EN
        chk("sat_cnt", 32'(err_count), 15);
`else
        chk("sat_cnt", 32'(err_count), 0);
`endif
        for (int i = 0; i < 2; i++) cyc(1'b0, 3'b000, 4'd0, 1'b0);
        do_reset("midblink");

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic       v, a;
            logic [2:0] s;
            logic [3:0] bb;
            v  = ($urandom_range(0, 2) == 0);
            s  = ($urandom_range(0, 2) == 0) ? 3'b110 : 3'($urandom);
            bb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            a  = ($urandom_range(0, 5) == 0) ? ~ack : ack;
            if (i % 200 == 199) do_reset("rnd");
            else cyc(v, s, bb, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/error_monitor.md
ERROR_MONITOR -- requirements
Module: error_monitor

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25000000, meaning cycles per LED half-period (legal range 1..2^26-1).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port op_valid  input  1  one-cycle pulse marking an executed ALU operation.
REQ-005 SHALL have port seletor  input  3  ALU operation selector, sampled when op_valid=1.
REQ-006 SHALL have port b  input  4  ALU operand B, sampled when op_valid=1.
REQ-007 SHALL have port ack  input  1  user clear request (debounced level, active-high).
REQ-008 SHALL have port ledr9  output  1  error indicator LED.
REQ-009 SHALL have port err_code  output  2  sticky causes; bit0 = divide-by-zero, bit1 = invalid operation.
REQ-010 SHALL have port err_count  output  4  total error events since reset, saturating.

Function
REQ-011 SHALL flag div_err when op_valid=1, seletor=3'b110 and b=4'b0000.
REQ-012 SHALL flag op_err when op_valid=1 and seletor=3'b111; div_err and op_err are mutually exclusive.
REQ-013 SHALL implement an FSM with states OK, ALERT and WAIT_REL.
REQ-014 SHALL transition OK->ALERT on any error; err_code bit set and ledr9=1 in the next cycle (latency 1).
REQ-015 SHALL, in ALERT, OR new error bits into err_code (sticky accumulation).
REQ-016 SHALL, in ALERT, toggle ledr9 every BLINK_DIV cycles, starting high and restarting the phase counter on OK->ALERT entry.
REQ-017 SHALL detect an ack rising edge internally (registered previous value); a level held high SHALL count as one edge.
REQ-018 SHALL, on an ack rising edge in ALERT with no error that cycle, clear err_code, drive ledr9=0 and go to WAIT_REL.
REQ-019 SHALL, on an ack rising edge and an error in the same cycle, stay in ALERT with err_code equal to the new error bit only; phase counter restarts.
REQ-020 SHALL go WAIT_REL->OK when ack=0; an error in WAIT_REL SHALL go directly to ALERT (error has priority over release).
REQ-021 SHALL ignore ack edges while in OK.
REQ-022 SHALL increment err_count by 1 per error event in any state, saturating at 15; ack never clears it.
REQ-023 SHALL keep ledr9=0 in OK and WAIT_REL.

Reset
REQ-024 SHALL, on rst_n=0, immediately force state OK, ledr9=0, err_code=2'b00, err_count=0, phase counter=0 and the ack edge register=0, independent of clk.
REQ-025 SHALL abort any blink or pending ack mid-operation on reset, with no stale state after release.

Configuration
REQ-026 SHALL honour macro ERROR_MONITOR_COUNT_EN: defined -> err_count per REQ-022; undefined -> counter logic absent and err_count tied to 4'b0000.

Structure
REQ-027 SHALL take constants OP_DIV=3'b110, OP_INV=3'b111, ERR_DIV_BIT=0, ERR_OP_BIT=1 and the FSM state encoding typedef from shared package ula_pkg.
REQ-028 SHALL instantiate one sub-module, edge_rise (registered rising-edge detector), for ack.

Verification (BLINK_DIV=4)
REQ-029 SHALL cover: op_valid, seletor=110, b=0 -> next cycle err_code=01, ledr9=1; ledr9 toggles every 4 cycles.
REQ-030 SHALL cover: seletor=110, b=5; seletor=101 with b=0 -> no error, ledr9=0, err_code=00.
REQ-031 SHALL cover: div error then seletor=111 error -> err_code=11, err_count=2; ack pulse -> err_code=00, ledr9=0, state OK after ack=0.
REQ-032 SHALL cover: ack rise and seletor=111 error in the same cycle while in ALERT -> err_code=10, ledr9=1, stays ALERT.
REQ-033 SHALL cover: 17 error events -> err_count=15 (macro defined) or 0 (macro undefined).
REQ-034 SHALL cover: rst_n asserted mid-blink between clock edges -> all outputs 0 before the next clk edge.
